// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared types and helpers for the clock-divider controller.
//               - state_t     : controller state encoding (IDLE/RUN/STOP)
//               - DIV_MIN     : smallest legal divide ratio
//               - high_start  : period position where the high phase begins
// Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int unsigned DIV_MIN = 2;

    // Low phase occupies positions 0..floor(N/2)-1, so the high phase
    // (and the tick) starts at floor(N/2).
    function automatic int unsigned high_start(input int unsigned n);
        return n >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Period counter and phase compare for the clock divider.
//               Holds the ratio in effect and produces the registered divided
//               clock and tick for the cycle that follows each edge.
// Ports       : clk_i     - system clock
//               rst_ni    - asynchronous active-low reset
//               run       - core is active in the next cycle
//               load_div  - take 'div' as the ratio from the next cycle on
//               div       - ratio to load
//               clk       - divided clock (registered)
//               tick      - pulse at the first high cycle of each period
//               boundary  - current cycle is the last position of a period
//               cur_div   - ratio currently in effect
// Revision    : 1.0 - initial release
// ============================================================================
module div_core
    import div_ctrl_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         run,
    input  logic         load_div,
    input  logic [W-1:0] div,
    output logic         clk,
    output logic         tick,
    output logic         boundary,
    output logic [W-1:0] cur_div
);

    logic         r_active;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_div;
    logic         r_clk;
    logic         r_tick;

    logic [W-1:0] w_div_nxt;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_high_start;
    logic         w_boundary;

    // The controller only loads a new ratio while idle or exactly at a
    // period boundary, so the counter restarts at 0 whenever the ratio
    // changes and can never sit above N-1.
    assign w_div_nxt    = load_div ? div : r_div;
    assign w_boundary   = r_active && (r_cnt == (r_div - W'(1)));
    assign w_high_start = W'(high_start(32'(w_div_nxt)));

    always_comb begin
        w_cnt_nxt = '0;
        if (run && r_active && !w_boundary) begin
            w_cnt_nxt = r_cnt + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_div    <= W'(DEFAULT_DIV);
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_active <= run;
            r_cnt    <= w_cnt_nxt;
            r_div    <= w_div_nxt;
            // Outputs are computed for the position the counter enters.
            r_clk    <= run && (w_cnt_nxt >= w_high_start);
            r_tick   <= run && (w_cnt_nxt == w_high_start);
        end
    end

    assign clk      = r_clk;
    assign tick     = r_tick;
    assign boundary = w_boundary;
    assign cur_div  = r_div;

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Runtime-programmable clock-divider controller. Sequences
//               start/stop and ratio changes so the divided clock never
//               carries a truncated or glitched phase.
// Ports       : clk_i        - system clock
//               rst_ni       - asynchronous active-low reset
//               en_i         - run request (level)
//               cfg_valid_i  - new ratio offered
//               cfg_div_i    - offered ratio N
//               cfg_ready_o  - a ratio can be accepted this cycle
//               cfg_err_o    - pulse: accepted ratio was illegal, discarded
//               clk_o        - divided clock (registered)
//               tick_o       - pulse in the first high cycle of each period
//               busy_o       - controller is not idle
//               cur_div_o    - ratio currently in effect
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         cfg_valid_i,
    input  logic [W-1:0] cfg_div_i,
    output logic         cfg_ready_o,
    output logic         cfg_err_o,
    output logic         clk_o,
    output logic         tick_o,
    output logic         busy_o,
    output logic [W-1:0] cur_div_o
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_pend_vld;
    logic [W-1:0] r_pend_div;
    logic         r_err;

    logic         w_ready;
    logic         w_xfer;
    logic         w_legal;
    logic         w_boundary;
    logic         w_apply;
    logic         w_load_div;
    logic [W-1:0] w_div;
    logic         w_run;

    // One ratio may be in flight while running; while stopping the
    // controller takes nothing so the wind-down period stays predictable.
    assign w_ready = (r_state == IDLE) || ((r_state == RUN) && !r_pend_vld);
    assign w_xfer  = cfg_valid_i && w_ready;
    assign w_legal = (cfg_div_i >= W'(DIV_MIN));

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        w_load_div  = 1'b0;
        w_div       = r_pend_div;
        case (r_state)
            IDLE: begin
                // No period in progress: a legal ratio takes effect at once,
                // including for a period started by the same edge.
                w_div      = cfg_div_i;
                w_load_div = w_xfer && w_legal;
                if (en_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_apply    = w_boundary && r_pend_vld;
                w_load_div = w_apply;
                if (!en_i) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                w_apply    = w_boundary && r_pend_vld;
                w_load_div = w_apply;
                if (en_i) begin
                    w_state_nxt = RUN;
                end else if (w_boundary) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_run = (w_state_nxt != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_pend_vld <= 1'b0;
            r_pend_div <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_xfer && !w_legal;
            // Apply and load are exclusive: loading needs an empty pending
            // slot, applying needs a full one.
            if (w_apply) begin
                r_pend_vld <= 1'b0;
            end else if ((r_state == RUN) && w_xfer && w_legal) begin
                r_pend_vld <= 1'b1;
                r_pend_div <= cfg_div_i;
            end
        end
    end

    div_core #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run      (w_run),
        .load_div (w_load_div),
        .div      (w_div),
        .clk      (clk_o),
        .tick     (tick_o),
        .boundary (w_boundary),
        .cur_div  (cur_div_o)
    );

    assign cfg_ready_o = w_ready;
    assign cfg_err_o   = r_err;
    assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire
